// File: rtl/display_share_arbiter.sv
// ---------------------------------------------------------------------------
// display_share_arbiter
//
// Shares one 4-digit seven-segment display between two requesters. The
// display is granted round-robin. A grant is held for at least DWELL cycles
// before it can pass to the other requester, so the shown value never
// flickers between sources. The granted source's 16-bit value is forwarded
// to the digit-scan mux with a per-digit enable mask. The mask can blank
// leading zero digits.
//
// Parameters
//   DWELL     minimum number of cycles a grant is held (>= 2)
//   CNT_W     dwell counter width, 2**CNT_W > DWELL
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   req[1:0]   level requests, held high while the display is wanted
//   data0      requester 0 value, digit k is nibble k (digit 0 = [3:0])
//   data1      requester 1 value, same layout
//   blank_lz   1 = blank leading zero digits
//   gnt[1:0]   one-hot grant, 00 when idle
//   disp_data  nibbles to the display mux
//   disp_en    per-digit enable, 1 = digit lit
//   busy       high whenever gnt != 00
//   done[1:0]  one-cycle pulse when requester i loses its grant
// ---------------------------------------------------------------------------
module display_share_arbiter #(
  parameter int DWELL = 1024,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic        blank_lz,
  output logic [1:0]  gnt,
  output logic [15:0] disp_data,
  output logic [3:0]  disp_en,
  output logic        busy,
  output logic [1:0]  done
);

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last;   // requester that most recently lost the grant
  logic             cur;    // requester holding the grant while in SHOW

  // Digit k (k >= 1) is lit when any nibble at or above k is non-zero.
  // Digit 0 is always lit, so a zero value still shows a single "0".
  function automatic logic [3:0] lz_mask(input logic [15:0] v, input logic blank);
    logic [3:0] m;
    // NOTE: every path assigns m before use, so no storage is implied.
    m = 4'b1111;
    if (blank) begin
      m[3] = |v[15:12];
      m[2] = m[3] | (|v[11:8]);
      m[1] = m[2] | (|v[7:4]);
      m[0] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  logic        oth;
  logic        idle_pick;
  logic        release_g;
  logic        expire;
  logic        hand_over;
  logic        load_idx;
  logic [15:0] load_val;
  logic [3:0]  load_en;

  assign oth = ~cur;

  // From IDLE the non-last requester wins if it asks. Otherwise the only
  // asking requester wins, which must then be 'last'.
  assign idle_pick = req[~last] ? ~last : last;

  // A release wins at any counter value. A hand-over on expiry needs the
  // other side to be asking, otherwise the grant stays saturated.
  assign release_g = (state == SHOW) && !req[cur];
  assign expire    = (state == SHOW) && req[cur] && (cnt == CNT_MAX);
  assign hand_over = (release_g || expire) && req[oth];

  // The select is always a known register bit. An X on the non-granted
  // data input therefore never reaches disp_data or disp_en.
  assign load_idx = (state == IDLE) ? idle_pick : (hand_over ? oth : cur);
  assign load_val = load_idx ? data1 : data0;
  assign load_en  = lz_mask(load_val, blank_lz);

  // NOTE: sequential state uses non-blocking assignments only. All
  // registers then update together on the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= 1'b1;
      cur       <= 1'b0;
      gnt       <= 2'b00;
      disp_data <= 16'h0000;
      disp_en   <= 4'b0000;
      busy      <= 1'b0;
      done      <= 2'b00;
    end else begin
      done <= 2'b00;
      case (state)
        IDLE: begin
          if (|req) begin
            state     <= SHOW;
            cur       <= idle_pick;
            gnt       <= onehot(idle_pick);
            busy      <= 1'b1;
            cnt       <= '0;
            disp_data <= load_val;
            disp_en   <= load_en;
          end
        end

        SHOW: begin
          if (release_g || hand_over) begin
            done <= onehot(cur);
            last <= cur;
          end

          if (hand_over) begin
            cur       <= oth;
            gnt       <= onehot(oth);
            cnt       <= '0;
            disp_data <= load_val;
            disp_en   <= load_en;
          end else if (release_g) begin
            state     <= IDLE;
            gnt       <= 2'b00;
            busy      <= 1'b0;
            disp_data <= 16'h0000;
            disp_en   <= 4'b0000;
          end else begin
            // Live tracking of the granted source. The counter saturates.
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            disp_data <= load_val;
            disp_en   <= load_en;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_display_share_arbiter
//
// Directed scenarios followed by randomized request/data traffic. After every
// clock edge all outputs are compared against a behavioural model. The model
// tracks "who owns the display, and for how many cycles". It computes the
// digit mask from the position of the highest non-zero nibble.
// ---------------------------------------------------------------------------
module tb_display_share_arbiter;

  localparam int DWELL = 4;
  localparam int CNT_W = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [15:0] data0 = 16'h0000;
  logic [15:0] data1 = 16'h0000;
  logic        blank_lz = 1'b0;
  logic [1:0]  gnt;
  logic [15:0] disp_data;
  logic [3:0]  disp_en;
  logic        busy;
  logic [1:0]  done;

  display_share_arbiter #(
    .DWELL(DWELL),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data0    (data0),
    .data1    (data1),
    .blank_lz (blank_lz),
    .gnt      (gnt),
    .disp_data(disp_data),
    .disp_en  (disp_en),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_owner;  // -1 = nobody holds the display
  int          m_held;   // cycles the owner has held it, capped at DWELL-1
  int          m_last;
  logic [15:0] m_data;
  logic [3:0]  m_en;
  logic [1:0]  m_done;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // The lit digits are 0 up to the highest non-zero nibble.
  function automatic logic [3:0] ref_mask(input logic [15:0] v, input logic blank);
    int h;
    if (!blank) return 4'hF;
    h = 0;
    for (int k = 1; k < 4; k++)
      if (((v >> (4 * k)) & 16'hF) != 0) h = k;
    return 4'((1 << (h + 1)) - 1);
  endfunction

  function automatic logic [15:0] src(input int i);
    return (i == 1) ? data1 : data0;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 1;
    m_data  = 16'h0000;
    m_en    = 4'h0;
    m_done  = 2'b00;
  endtask

  task automatic model_edge();
    int o;
    if (!rst) begin
      model_reset();
      return;
    end
    m_done = 2'b00;
    if (m_owner < 0) begin
      if (req != 2'b00) begin
        m_owner = req[1 - m_last] ? (1 - m_last) : m_last;
        m_held  = 0;
        m_data  = src(m_owner);
        m_en    = ref_mask(m_data, blank_lz);
      end
    end else begin
      o = 1 - m_owner;
      if (!req[m_owner] || (m_held >= DWELL - 1 && req[o])) begin
        m_done[m_owner] = 1'b1;
        m_last = m_owner;
        if (req[o]) begin
          m_owner = o;
          m_held  = 0;
          m_data  = src(o);
          m_en    = ref_mask(m_data, blank_lz);
        end else begin
          m_owner = -1;
          m_data  = 16'h0000;
          m_en    = 4'h0;
        end
      end else begin
        if (m_held < DWELL - 1) m_held++;
        m_data = src(m_owner);
        m_en   = ref_mask(m_data, blank_lz);
      end
    end
  endtask

  task automatic compare_all(input string where);
    logic [1:0] exp_gnt;
    exp_gnt = (m_owner < 0) ? 2'b00 : ((m_owner == 1) ? 2'b10 : 2'b01);
    check({where, "_gnt"},  16'(gnt),  16'(exp_gnt));
    check({where, "_data"}, disp_data, m_data);
    check({where, "_en"},   16'(disp_en), 16'(m_en));
    check({where, "_busy"}, 16'(busy), 16'(m_owner >= 0));
    check({where, "_done"}, 16'(done), 16'(m_done));
  endtask

  // One clock edge: update the model from the inputs sampled at the edge,
  // then compare 1 time unit later. Stimulus changes after this returns.
  task automatic step(input string where);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(where);
  endtask

  // Asynchronous reset pulse placed between edges (caller is at edge+1).
  task automatic async_reset_pulse(input string where);
    #2 rst = 1'b0;
    #1 model_reset();
    compare_all(where);
    #2 rst = 1'b1;
  endtask

  initial begin
    model_reset();

    // Reset and start: reset held with req=01, outputs stay 0.
    rst = 1'b0; req = 2'b01; data0 = 16'h1234; data1 = 16'h0000; blank_lz = 1'b0;
    #2 compare_all("rst_hold");
    step("rst_edge");
    rst = 1'b1;
    step("start");
    check("tp_start_gnt",  16'(gnt), 16'h0001);
    check("tp_start_data", disp_data, 16'h1234);
    check("tp_start_en",   16'(disp_en), 16'h000F);
    req = 2'b00;
    step("start_rel");
    step("idle1");

    // Return last to 1 so requester 0 wins the contested start below.
    async_reset_pulse("rst2");

    // Dwell hand-over with both requesting and leading-zero blanking.
    data0 = 16'h00A0; data1 = 16'h0003; blank_lz = 1'b1; req = 2'b11;
    step("dwell");
    check("tp_dwell_gnt0", 16'(gnt), 16'h0001);
    check("tp_dwell_en0",  16'(disp_en), 16'h0003);
    repeat (3) step("dwell");
    step("dwell_ho");
    check("tp_dwell_done", 16'(done), 16'h0001);
    check("tp_dwell_gnt1", 16'(gnt), 16'h0002);
    check("tp_dwell_data", disp_data, 16'h0003);
    check("tp_dwell_en1",  16'(disp_en), 16'h0001);
    repeat (3) step("dwell");
    step("dwell_back");
    check("tp_dwell_back", 16'(gnt), 16'h0001);
    req = 2'b00;
    step("dwell_rel");
    step("idle2");

    // No preemption before the dwell expires.
    data0 = 16'h0100; data1 = 16'h8000; req = 2'b01;
    step("npre");
    step("npre");
    req = 2'b11;
    step("npre");
    step("npre_c3");
    check("tp_npre_hold", 16'(gnt), 16'h0001);
    step("npre_ho");
    check("tp_npre_sw", 16'(gnt), 16'h0002);
    check("tp_npre_en", 16'(disp_en), 16'h000F);
    req = 2'b00;
    step("npre_rel");
    step("idle3");

    // Early release with the other side idle.
    req = 2'b01;
    step("early");
    step("early");
    req = 2'b00;
    step("early_rel");
    check("tp_early_done", 16'(done), 16'h0001);
    check("tp_early_gnt",  16'(gnt), 16'h0000);
    check("tp_early_data", disp_data, 16'h0000);
    step("idle4");

    // Saturation. The unused source carries X, which must stay invisible.
    data0 = 16'h0000; data1 = 'x; req = 2'b01;
    repeat (10) step("sat");
    check("tp_sat_gnt",  16'(gnt), 16'h0001);
    check("tp_sat_done", 16'(done), 16'h0000);
    check("tp_sat_en",   16'(disp_en), 16'h0001);
    data1 = 16'h0042; req = 2'b11;
    step("sat_ho");
    check("tp_sat_sw", 16'(gnt), 16'h0002);

    // Asynchronous reset while requester 1 holds the display.
    #2 rst = 1'b0;
    #1 model_reset();
    compare_all("arst");
    check("tp_arst_gnt", 16'(gnt), 16'h0000);
    req = 2'b11;
    #3 rst = 1'b1;
    step("arst_rel");
    check("tp_arst_first", 16'(gnt), 16'h0001);

    // Randomized traffic: sticky requests, changing data, rare resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) req[0] = ~req[0];
      if ($urandom_range(0, 7) == 0) req[1] = ~req[1];
      if ($urandom_range(0, 3) == 0) data0 = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) data1 = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      step("rand");
      if ($urandom_range(0, 99) == 0) async_reset_pulse("rand_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_share_arbiter.md
Name: display_share_arbiter

Overview:
- Shares the single 4-digit seven-segment display between two requesters, e.g. a measurement path and a status path.
- Grants the display round-robin with a guaranteed minimum dwell time, so a digit value never flickers between sources.
- Forwards the granted source's 16-bit value (four hex nibbles) and a per-digit enable mask with optional leading-zero blanking.
- Sits directly upstream of the digit-scan/segment-decode mux.

Parameters:
- DWELL, 1024: minimum number of clk cycles a grant is held before it can pass to the other requester (legal range ≥2).
- CNT_W, 16: width of the dwell counter; must satisfy 2^CNT_W > DWELL.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  2  req[i] high = requester i wants the display; level, held while wanted.
- data0  in  16  requester 0 value; nibble k drives digit k, digit 0 is [3:0].
- data1  in  16  requester 1 value; same layout as data0.
- blank_lz  in  1  1 = blank leading zero digits.
- gnt  out  2  one-hot grant, 00 when idle.
- disp_data  out  16  nibbles to the display mux.
- disp_en  out  4  per-digit enable, 1 = digit lit.
- busy  out  1  high whenever gnt != 00.
- done  out  2  1-cycle pulse on done[i] when requester i loses its grant.

Behaviour:
- Reset (rst low, asynchronous):
  - gnt=00, disp_data=0, disp_en=0000, busy=0, done=00.
  - Dwell counter=0, state=IDLE, round-robin pointer last=1, so requester 0 wins first.
  - On release, the first action occurs on the first rising edge with rst high.
- All outputs are registered.
- FSM states are IDLE and SHOW.
- IDLE:
  - gnt=00, disp_en=0000, disp_data holds 0.
  - On an edge with req!=00, grant goes to the requester not equal to last if it requests, else to the one requesting. That edge sets gnt, busy=1 and counter=0, and loads disp_data from the granted source. Next state is SHOW.
  - Latency from req sampled high to gnt high is 1 edge.
- SHOW (granted requester g, other o):
  - disp_data <= data_g every cycle (live tracking, 1-cycle latency).
  - Counter increments each cycle and saturates at DWELL-1.
- Release (req[g] sampled low), at any counter value:
  - done[g] pulses; last<=g.
  - If req[o] is high: gnt<=o, counter<=0, stay in SHOW.
  - Otherwise: gnt<=00, busy<=0, disp_en<=0000, disp_data<=0, next state IDLE.
- Dwell expiry (counter==DWELL-1 and req[g] high):
  - If req[o] is high: hand-over, with done[g] pulse, gnt<=o, counter<=0, last<=g.
  - Otherwise: keep g, counter stays saturated, and hand-over occurs on the first later edge where req[o] is high.
- Before dwell expiry, req[o] is ignored; there is no preemption.
- Simultaneous release of g and req[o] high while the counter is below DWELL-1 is treated as release: hand-over happens immediately.
- Both req bits high from IDLE: grant goes to the non-last requester. Two requesters held high continuously alternate every DWELL cycles.
- disp_en in SHOW, computed from the value being loaded into disp_data:
  - blank_lz=0 gives 1111.
  - blank_lz=1: digit k (k=1..3) is lit if any nibble j≥k is non-zero. Digit 0 is always lit.
  - Examples: value 0x0000 → 0001; 0x00A0 → 0011; 0x0100 → 0111; 0x8000 → 1111.
- done is never high on two consecutive cycles for the same requester unless that requester is re-granted and released again.
- gnt is always one-hot or zero.
- X on unused data inputs (the non-granted source) must not propagate to the outputs.

Test Plan (DWELL=4):
- Reset/start: hold rst low with req=01, release rst. Outputs stay 0 until the first edge; then gnt=01, busy=1, disp_data=data0=0x1234, disp_en=1111.
- Dwell hand-over: req=11 from IDLE, data0=0x00A0, data1=0x0003, blank_lz=1.
  - gnt=01, disp_en=0011 for 4 cycles.
  - Then done=01 pulses 1 cycle, and gnt=10, disp_data=0x0003, disp_en=0001.
  - After 4 more cycles gnt returns to 01.
- No preemption: req=01 granted, assert req[1] at counter=1. gnt stays 01 until counter=3, then switches to 10.
- Early release: req=01 granted, drop req[0] at counter=1 with req[1]=0. Next edge: done=01, gnt=00, busy=0, disp_en=0000, disp_data=0.
- Saturation: req=01 only for 10 cycles. gnt stays 01 and done stays 00. Assert req[1] at cycle 10: gnt=10 on the next edge.
- Async reset mid-SHOW: pull rst low between edges while gnt=10. All outputs go to 0 immediately. After release with req=11, the first grant goes to requester 0 (last=1).
